// File: rtl/neureka_stream_router.sv
// Descriptor-driven router: steers beats from the main or alternate load stream to one of NB_OUT consumers.
// Optional per-output handshake counters on stat_beats_o when NEUREKA_ROUTER_STATS_EN is defined.
module neureka_stream_router #(
  parameter int unsigned NB_OUT     = 4,
  parameter int unsigned DW         = 288,
  parameter int unsigned DESC_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           enable_i,
  input  logic                           desc_valid_i,
  output logic                           desc_ready_o,
  input  logic [$clog2(NB_OUT):0]        desc_chan_i,
  input  logic                           desc_alt_i,
  input  logic [LEN_W-1:0]               desc_len_i,
  input  logic                           src_valid_i,
  output logic                           src_ready_o,
  input  logic [DW-1:0]                  src_data_i,
  input  logic [DW/8-1:0]                src_strb_i,
  input  logic                           alt_valid_i,
  output logic                           alt_ready_o,
  input  logic [DW-1:0]                  alt_data_i,
  input  logic [DW/8-1:0]                alt_strb_i,
  output logic [NB_OUT-1:0]              out_valid_o,
  input  logic [NB_OUT-1:0]              out_ready_i,
  output logic [NB_OUT*DW-1:0]           out_data_o,
  output logic [NB_OUT*DW/8-1:0]         out_strb_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
`ifdef NEUREKA_ROUTER_STATS_EN
  ,
  output logic [NB_OUT*32-1:0]           stat_beats_o
`endif
);

  localparam int unsigned CW = $clog2(NB_OUT) + 1;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = $clog2(DESC_DEPTH);

  typedef enum logic {IDLE, ROUTE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    fifo_chan [DESC_DEPTH];
  logic             fifo_alt  [DESC_DEPTH];
  logic [LEN_W-1:0] fifo_len  [DESC_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             full, empty, push, pop, retire;
  logic [CW-1:0]    chan_q;
  logic             alt_q;
  logic [LEN_W-1:0] cnt_q;
  logic             done_q, err_q;
  logic             active, bad, tgt_ready, sel_valid, sel_ready, hs;
  logic [DW-1:0]    sel_data;
  logic [SW-1:0]    sel_strb;

  assign full         = (count == (PW+1)'(DESC_DEPTH));
  assign empty        = (count == '0);
  assign push         = desc_valid_i && !full;
  assign desc_ready_o = !full;
  assign busy_o       = (state == ROUTE) || !empty;
  assign done_o       = done_q;
  assign err_o        = err_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_chan[wr_ptr] <= desc_chan_i;
      fifo_alt[wr_ptr]  <= desc_alt_i;
      fifo_len[wr_ptr]  <= desc_len_i;
    end
  end

  always_comb begin
    sel_valid = alt_q ? alt_valid_i : src_valid_i;
    sel_data  = alt_q ? alt_data_i  : src_data_i;
    sel_strb  = alt_q ? alt_strb_i  : src_strb_i;
    bad       = (chan_q >= CW'(NB_OUT));
    active    = (state == ROUTE) && (cnt_q != '0);
    // an out-of-range channel matches no output, so the drain keeps ready high
    tgt_ready = bad;
    for (int unsigned i = 0; i < NB_OUT; i++) begin
      if (chan_q == CW'(i)) tgt_ready = out_ready_i[i];
    end
    sel_ready   = active && enable_i && tgt_ready;
    hs          = sel_valid && sel_ready;
    src_ready_o = sel_ready && !alt_q;
    alt_ready_o = sel_ready && alt_q;
  end

  always_comb begin
    out_valid_o = '0;
    out_data_o  = '0;
    out_strb_o  = '0;
    for (int unsigned i = 0; i < NB_OUT; i++) begin
      if (active && !bad && chan_q == CW'(i)) begin
        out_valid_o[i]         = sel_valid && enable_i;
        out_data_o[i*DW +: DW] = sel_data;
        out_strb_o[i*SW +: SW] = sel_strb;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    retire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && enable_i) begin
          pop       = 1'b1;
          state_nxt = ROUTE;
        end
      end
      ROUTE: begin
        if (enable_i && (cnt_q == '0 || (hs && cnt_q == LEN_W'(1)))) begin
          retire = 1'b1;
          if (!empty) pop = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      chan_q <= '0;
      alt_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (clear_i) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      chan_q <= '0;
      alt_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= retire;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      // a pop on the last beat reloads the counter, so chaining has no bubble
      if (pop) begin
        chan_q <= fifo_chan[rd_ptr];
        alt_q  <= fifo_alt[rd_ptr];
        cnt_q  <= fifo_len[rd_ptr];
        if (fifo_chan[rd_ptr] >= CW'(NB_OUT)) err_q <= 1'b1;
      end else if (hs) begin
        cnt_q <= cnt_q - LEN_W'(1);
      end
    end
  end

`ifdef NEUREKA_ROUTER_STATS_EN
  logic [31:0] stat_q [NB_OUT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NB_OUT; i++) stat_q[i] <= '0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < NB_OUT; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_OUT; i++) begin
        if (hs && !bad && chan_q == CW'(i)) stat_q[i] <= stat_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_beats_o = '0;
    for (int unsigned i = 0; i < NB_OUT; i++) stat_beats_o[i*32 +: 32] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_neureka_stream_router.sv
// Directed bench for neureka_stream_router: queue-based reference model checked every cycle,
// plus literal per-scenario expectations on beat counts, pulses and timing.
module tb_neureka_stream_router;
  localparam int NB_OUT = 4;
  localparam int DW     = 288;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = 16;
  localparam int CW     = 3;
  localparam int SW     = DW / 8;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, enable = 1'b1;
  logic desc_valid = 1'b0, desc_ready, desc_alt = 1'b0;
  logic [CW-1:0] desc_chan = '0;
  logic [LEN_W-1:0] desc_len = '0;
  logic src_valid = 1'b0, src_ready, alt_valid = 1'b0, alt_ready;
  logic [DW-1:0] src_data, alt_data;
  logic [SW-1:0] src_strb, alt_strb;
  logic [NB_OUT-1:0] out_valid, out_ready = '0;
  logic [NB_OUT*DW-1:0] out_data;
  logic [NB_OUT*SW-1:0] out_strb;
  logic busy, done, err;
`ifdef NEUREKA_ROUTER_STATS_EN
  logic [NB_OUT*32-1:0] stat_beats;
`endif

  neureka_stream_router #(.NB_OUT(NB_OUT), .DW(DW), .DESC_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
    .desc_valid_i(desc_valid), .desc_ready_o(desc_ready), .desc_chan_i(desc_chan),
    .desc_alt_i(desc_alt), .desc_len_i(desc_len),
    .src_valid_i(src_valid), .src_ready_o(src_ready), .src_data_i(src_data), .src_strb_i(src_strb),
    .alt_valid_i(alt_valid), .alt_ready_o(alt_ready), .alt_data_i(alt_data), .alt_strb_i(alt_strb),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_strb_o(out_strb),
    .busy_o(busy), .done_o(done), .err_o(err)
`ifdef NEUREKA_ROUTER_STATS_EN
    , .stat_beats_o(stat_beats)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [31:0] w);
    return {9{w}};
  endfunction
  function automatic logic [SW-1:0] mk_strb(input logic [31:0] w);
    return {w[3:0] ^ 4'h5, w};
  endfunction

  // stream sources advance only on a handshake, so delivered words reveal ordering
  logic [31:0] src_seq = 0, alt_seq = 0;
  bit src_hs_q = 0, alt_hs_q = 0, toggle = 0;
  always_comb begin
    src_data = mk_data(32'hA000_0000 + src_seq);
    src_strb = mk_strb(32'hA000_0000 + src_seq);
    alt_data = mk_data(32'hB000_0000 + alt_seq);
    alt_strb = mk_strb(32'hB000_0000 + alt_seq);
  end

  // reference model: descriptor queue plus the one being served
  typedef struct { int chan; bit alt; int len; } desc_t;
  desc_t mq[$];
  bit m_active, m_alt, m_err, m_done;
  int m_rem, m_chan;
  logic [31:0] m_stats [NB_OUT];

  task automatic m_reset();
    mq.delete();
    m_active = 0; m_alt = 0; m_err = 0; m_done = 0; m_rem = 0; m_chan = 0;
    for (int i = 0; i < NB_OUT; i++) m_stats[i] = 0;
  endtask

  // observations of the DUT for the scenario-level literal checks
  int cyc = 0, beats[NB_OUT], done_cnt, src_hs_cnt, alt_hs_cnt, acc_cnt, acc_cyc;
  int first_cyc, last_cyc, hs_dis;
  logic [31:0] out3_words[$];

  task automatic obs_reset();
    for (int i = 0; i < NB_OUT; i++) beats[i] = 0;
    done_cnt = 0; src_hs_cnt = 0; alt_hs_cnt = 0; acc_cnt = 0; acc_cyc = -1;
    first_cyc = -1; last_cyc = -1; hs_dis = 0;
    out3_words.delete();
  endtask

  bit routing, bad, sel_v, tgt_r, sel_r, hs, retire, e_src_r, e_alt_r;
  logic [NB_OUT-1:0] e_valid;
  logic [NB_OUT*DW-1:0] e_data;
  logic [NB_OUT*SW-1:0] e_strb;
  desc_t d;

  always @(negedge clk) begin
    if (!rst_n) begin
      src_hs_q = 0; alt_hs_q = 0;
    end else begin
      cyc++;
      routing = m_active && m_rem > 0;
      bad     = m_chan >= NB_OUT;
      sel_v   = m_alt ? alt_valid : src_valid;
      if (bad) tgt_r = 1; else tgt_r = out_ready[m_chan];
      sel_r   = routing && enable && tgt_r;
      e_src_r = sel_r && !m_alt;
      e_alt_r = sel_r && m_alt;
      e_valid = '0; e_data = '0; e_strb = '0;
      if (routing && !bad) begin
        e_valid[m_chan] = enable && sel_v;
        e_data[m_chan*DW +: DW] = m_alt ? alt_data : src_data;
        e_strb[m_chan*SW +: SW] = m_alt ? alt_strb : src_strb;
      end
      chk("out_valid", 64'(out_valid), 64'(e_valid));
      chk("src_ready", 64'(src_ready), 64'(e_src_r));
      chk("alt_ready", 64'(alt_ready), 64'(e_alt_r));
      chk("desc_ready", 64'(desc_ready), 64'(mq.size() < DEPTH));
      chk("busy", 64'(busy), 64'(m_active || mq.size() > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("err", 64'(err), 64'(m_err));
      n_tests++;
      if (out_data !== e_data || out_strb !== e_strb) begin
        n_fail++;
        $display("FAIL out_data: got %h/%h expected %h/%h (low bits) at %0t",
                 out_data[63:0], out_strb[31:0], e_data[63:0], e_strb[31:0], $time);
      end
`ifdef NEUREKA_ROUTER_STATS_EN
      for (int i = 0; i < NB_OUT; i++) chk("stat_beats", 64'(stat_beats[i*32 +: 32]), 64'(m_stats[i]));
`endif
      for (int i = 0; i < NB_OUT; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          beats[i]++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (i == 3) out3_words.push_back(out_data[3*DW +: 32]);
        end
      end
      src_hs_q = src_valid && src_ready;
      alt_hs_q = alt_valid && alt_ready;
      if (src_hs_q) src_hs_cnt++;
      if (alt_hs_q) alt_hs_cnt++;
      if (!enable && (src_ready || alt_ready || |(out_valid & out_ready))) hs_dis++;
      if (done) done_cnt++;
      if (desc_valid && desc_ready) begin acc_cnt++; acc_cyc = cyc; end

      hs = sel_v && sel_r;
      if (clear) m_reset();
      else begin
        retire = m_active && enable && (m_rem == 0 || (hs && m_rem == 1));
        m_done = retire;
        if (hs) begin
          m_rem--;
          if (!bad) m_stats[m_chan]++;
        end
        if (retire) m_active = 0;
        begin
          bit pushed;
          pushed = desc_valid && mq.size() < DEPTH;
          if (enable && !m_active && mq.size() > 0) begin
            d = mq.pop_front();
            m_active = 1; m_chan = d.chan; m_alt = d.alt; m_rem = d.len;
            if (d.chan >= NB_OUT) m_err = 1;
          end
          if (pushed) mq.push_back('{int'(desc_chan), desc_alt, int'(desc_len)});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (src_hs_q) src_seq++;
    if (alt_hs_q) alt_seq++;
    if (toggle) out_ready[3] = ~out_ready[3];
  endtask

  task automatic push(input int ch, input bit a, input int len);
    desc_chan = CW'(ch); desc_alt = a; desc_len = LEN_W'(len); desc_valid = 1;
    tick();
    desc_valid = 0;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int k = 0; k < budget && done_cnt < n; k++) tick();
  endtask

  initial begin
    m_reset(); obs_reset();
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_src_ready", 64'(src_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    src_valid = 1; alt_valid = 1;
    tick();

    // single route
    obs_reset(); out_ready = 4'b0100;
    push(2, 0, 8);
    wait_done(1, 30); repeat (3) tick();
    chk("single_beats2", 64'(beats[2]), 64'd8);
    chk("single_other_beats", 64'(beats[0] + beats[1] + beats[3]), 64'd0);
    chk("single_done", 64'(done_cnt), 64'd1);
    chk("single_span", 64'(last_cyc - first_cyc), 64'd7);
    chk("single_latency", 64'(first_cyc - acc_cyc), 64'd2);

    // back-to-back, descriptors queued while stalled
    obs_reset(); out_ready = 4'b0011; enable = 0;
    push(0, 0, 4); push(1, 1, 3);
    enable = 1;
    wait_done(2, 30); repeat (3) tick();
    chk("b2b_beats0", 64'(beats[0]), 64'd4);
    chk("b2b_beats1", 64'(beats[1]), 64'd3);
    chk("b2b_span", 64'(last_cyc - first_cyc), 64'd6);
    chk("b2b_alt_hs", 64'(alt_hs_cnt), 64'd3);
    chk("b2b_done", 64'(done_cnt), 64'd2);

    // backpressure plus a 3-cycle stall
    obs_reset(); out_ready = 4'b1000; toggle = 1;
    push(3, 0, 5);
    repeat (3) tick();
    enable = 0; repeat (3) tick(); enable = 1;
    wait_done(1, 40); toggle = 0; repeat (2) tick();
    chk("bp_beats3", 64'(beats[3]), 64'd5);
    chk("bp_src_hs", 64'(src_hs_cnt), 64'd5);
    chk("bp_hs_while_disabled", 64'(hs_dis), 64'd0);
    chk("bp_words", 64'(out3_words.size()), 64'd5);
    for (int k = 1; k < out3_words.size(); k++)
      chk("bp_order", 64'(out3_words[k] - out3_words[0]), 64'(k));

    // FIFO full: 1 in ROUTE + 4 queued, then further pushes refused
    obs_reset(); out_ready = '0;
    desc_chan = 0; desc_alt = 0; desc_len = 2; desc_valid = 1;
    repeat (8) tick();
    chk("full_accepted", 64'(acc_cnt), 64'd5);
    chk("full_desc_ready", 64'(desc_ready), 64'd0);
    out_ready = 4'b0001;
    for (int k = 0; k < 20 && acc_cnt < 6; k++) tick();
    desc_valid = 0;
    chk("full_done_before_6th", 64'(done_cnt), 64'd1);
    wait_done(6, 60); repeat (2) tick();
    chk("full_beats0", 64'(beats[0]), 64'd12);
    chk("full_done", 64'(done_cnt), 64'd6);

    // out-of-range channel drains, then a zero-length descriptor
    obs_reset(); out_ready = '1;
    push(NB_OUT, 0, 2); push(1, 0, 0);
    wait_done(2, 30); repeat (3) tick();
    chk("bad_src_drained", 64'(src_hs_cnt), 64'd2);
    chk("bad_no_beats", 64'(beats[0] + beats[1] + beats[2] + beats[3]), 64'd0);
    chk("bad_done", 64'(done_cnt), 64'd2);
    chk("bad_err", 64'(err), 64'd1);
    clear = 1; tick(); clear = 0;
    chk("bad_err_cleared", 64'(err), 64'd0);

    // abort mid-route
    obs_reset(); out_ready = 4'b0001;
    push(0, 0, 10);
    for (int k = 0; k < 20 && beats[0] < 3; k++) tick();
    clear = 1; tick(); clear = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_fifo_empty", 64'(desc_ready), 64'd1);
`ifdef NEUREKA_ROUTER_STATS_EN
    chk("abort_stats", 64'(stat_beats), 64'd0);
`endif
    repeat (4) tick();
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_partial", 64'(beats[0] < 10), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
